// File: rtl/rat_int_pkg.sv
// Shared definitions for the RAT MCU interrupt controller.
package rat_int_pkg;

  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_EOI  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } int_state_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [2:0] prio_enc(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rat_int_edge.sv
// One request line: optional 2-flop synchroniser plus rising-edge detector.
module rat_int_edge #(
  parameter bit SYNC_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_i,
  input  logic irq_i,
  output logic rise_c_o
);

  logic irq_s;
  logic irq_s_d_q;
  logic armed;

  // A line already high when reset releases is not an event: detection is
  // held off until the synchroniser and edge flop have been primed.
  if (SYNC_EN) begin : g_sync
    logic [1:0] sync_q;
    logic [2:0] arm_q;

    // Synchroniser stages and arming delay matched to their depth.
    always_ff @(posedge clk) begin
      if (rst_i) begin
        sync_q <= 2'b00;
        arm_q  <= 3'b000;
      end else begin
        sync_q <= {sync_q[0], irq_i};
        arm_q  <= {arm_q[1:0], 1'b1};
      end
    end

    assign irq_s = sync_q[1];
    assign armed = arm_q[2];
  end else begin : g_nosync
    logic arm_q;

    // Arming delay of one cycle covers the edge flop alone.
    always_ff @(posedge clk) begin
      if (rst_i) arm_q <= 1'b0;
      else       arm_q <= 1'b1;
    end

    assign irq_s = irq_i;
    assign armed = arm_q;
  end

  // Previous sample of the (synchronised) line for edge detection.
  always_ff @(posedge clk) begin
    if (rst_i) irq_s_d_q <= 1'b0;
    else       irq_s_d_q <= irq_s;
  end

  assign rise_c_o = armed & irq_s & ~irq_s_d_q;

endmodule

// File: rtl/rat_int_ctrl.sv
// Prioritised interrupt controller with a 4-register port-bus window.
module rat_int_ctrl
  import rat_int_pkg::*;
#(
  parameter int unsigned N_SRC   = 8,
  parameter logic [7:0]  BASE_ID = 8'h40,
  parameter bit          SYNC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  input  logic             INT_ACK,
  output logic             INTV,
  output logic [7:0]       IN_DATA,
  output logic             IN_SEL
);

  localparam logic [7:0] SRC_MASK = 8'((9'd1 << N_SRC) - 9'd1);

  if (N_SRC < 1 || N_SRC > 8) begin : g_bad_nsrc
    $error("rat_int_ctrl: N_SRC must be 1..8");
  end
  if (BASE_ID > 8'hFC) begin : g_bad_base
    $error("rat_int_ctrl: register window would wrap past 8'hFF");
  end

  logic [N_SRC-1:0] rise;
  logic [7:0]       rise8;
  logic [7:0]       win_off;
  logic             in_win;
  logic [1:0]       reg_sel;
  logic             wr_mask, wr_pend, wr_eoi;
  logic [7:0]       eligible;
  logic             ack_take;
  logic [7:0]       mask_q, mask_d;
  logic [7:0]       pend_q, pend_d;
  logic [2:0]       active_q;
  logic             isr_q;
  logic             intv_q;
  int_state_t       state_q;

  for (genvar i = 0; i < N_SRC; i++) begin : g_edge
    rat_int_edge #(.SYNC_EN(SYNC_EN)) u_edge (
      .clk      (clk),
      .rst_i    (RESET),
      .irq_i    (IRQ[i]),
      .rise_c_o (rise[i])
    );
  end

  assign rise8    = 8'(rise);
  assign win_off  = PORT_ID - BASE_ID;
  assign in_win   = (win_off < 8'd4);
  assign reg_sel  = win_off[1:0];
  assign wr_mask  = IO_STRB && in_win && (reg_sel == REG_MASK);
  assign wr_pend  = IO_STRB && in_win && (reg_sel == REG_PEND);
  assign wr_eoi   = IO_STRB && in_win && (reg_sel == REG_EOI);
  assign eligible = pend_q & mask_q;
  assign ack_take = (state_q == ASSERT) && INT_ACK;

  // Next mask/pending: W1C and ack clear first, a new edge then sets (set wins).
  always_comb begin
    mask_d = mask_q;
    pend_d = pend_q;
    if (wr_mask)  mask_d = OUT_PORT & SRC_MASK;
    if (wr_pend)  pend_d = pend_d & ~OUT_PORT;
    if (ack_take) pend_d = pend_d & ~(8'h01 << active_q);
    pend_d = (pend_d | rise8) & SRC_MASK;
  end

  // Mask and pending registers.
  always_ff @(posedge clk) begin
    if (RESET) begin
      mask_q <= 8'h00;
      pend_q <= 8'h00;
    end else begin
      mask_q <= mask_d;
      pend_q <= pend_d;
    end
  end

  // Arbitration / service FSM with registered INTV.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q  <= IDLE;
      active_q <= 3'd0;
      isr_q    <= 1'b0;
      intv_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|eligible) begin
            state_q  <= ASSERT;
            active_q <= prio_enc(eligible);
            intv_q   <= 1'b1;
          end
        end
        ASSERT: begin
          if (INT_ACK) begin
            state_q <= SERVICE;
            isr_q   <= 1'b1;
            intv_q  <= 1'b0;
          end else if (!eligible[active_q]) begin
            state_q  <= IDLE;
            active_q <= 3'd0;
            intv_q   <= 1'b0;
          end
        end
        SERVICE: begin
          if (wr_eoi) begin
            state_q  <= IDLE;
            active_q <= 3'd0;
            isr_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          intv_q  <= 1'b0;
        end
      endcase
    end
  end

  assign INTV = intv_q;

  // Read mux for the IN_PORT path, driven straight from PORT_ID.
  always_comb begin
    IN_SEL  = in_win;
    IN_DATA = 8'h00;
    if (in_win) begin
      case (reg_sel)
        REG_MASK: IN_DATA = mask_q;
        REG_PEND: IN_DATA = pend_q;
        REG_STAT: IN_DATA = {isr_q, intv_q, 3'b000, active_q};
        default:  IN_DATA = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Directed bench for rat_int_ctrl (N_SRC=8, BASE_ID=8'h40, SYNC_EN=0).
module tb_rat_int_ctrl;
  import rat_int_pkg::*;

  logic       clk = 1'b0;
  logic       RESET;
  logic [7:0] IRQ;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic       INT_ACK;
  logic       INTV;
  logic [7:0] IN_DATA;
  logic       IN_SEL;

  int n_tests = 0;
  int n_fail  = 0;

  rat_int_ctrl #(.N_SRC(8), .BASE_ID(8'h40), .SYNC_EN(1'b0)) dut (
    .clk      (clk),
    .RESET    (RESET),
    .IRQ      (IRQ),
    .PORT_ID  (PORT_ID),
    .OUT_PORT (OUT_PORT),
    .IO_STRB  (IO_STRB),
    .INT_ACK  (INT_ACK),
    .INTV     (INTV),
    .IN_DATA  (IN_DATA),
    .IN_SEL   (IN_SEL)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    PORT_ID  = addr;
    OUT_PORT = data;
    IO_STRB  = 1'b1;
    tick();
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    PORT_ID = addr;
    #1;
    check_eq(tag, IN_DATA, exp);
    PORT_ID = 8'h00;
  endtask

  task automatic ack();
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
  endtask

  // INTV may only be high while the controller is in ASSERT.
  always @(negedge clk) begin
    if (INTV === 1'b1)
      check_eq("intv_only_in_assert", {7'b0, dut.state_q == ASSERT}, 8'h01);
  end

  initial begin
    RESET = 1'b1; IRQ = 8'hFF; PORT_ID = 8'h00; OUT_PORT = 8'h00;
    IO_STRB = 1'b0; INT_ACK = 1'b0;

    // 1. reset with all lines held high
    tick(); tick();
    RESET = 1'b0;
    tick(); tick(); tick();
    check_eq("rst_intv", {7'b0, INTV}, 8'h00);
    rd("rst_mask", 8'h40, 8'h00);
    rd("rst_pend", 8'h41, 8'h00);
    rd("rst_stat", 8'h42, 8'h00);
    rd("rst_eoi_rd", 8'h43, 8'h00);
    IRQ = 8'h00;
    tick();

    // window select
    PORT_ID = 8'h3F; #1;
    check_eq("sel_3f", {7'b0, IN_SEL}, 8'h00);
    check_eq("data_3f", IN_DATA, 8'h00);
    PORT_ID = 8'h44; #1;
    check_eq("sel_44", {7'b0, IN_SEL}, 8'h00);
    PORT_ID = 8'h40; #1;
    check_eq("sel_40", {7'b0, IN_SEL}, 8'h01);
    PORT_ID = 8'h43; #1;
    check_eq("sel_43", {7'b0, IN_SEL}, 8'h01);
    PORT_ID = 8'h00;

    // 2. basic flow on source 2
    wr(8'h40, 8'h04);
    rd("b_mask", 8'h40, 8'h04);
    IRQ = 8'h04; tick(); IRQ = 8'h00;
    rd("b_pend", 8'h41, 8'h04);
    check_eq("b_intv_1clk", {7'b0, INTV}, 8'h00);
    tick();
    check_eq("b_intv_2clk", {7'b0, INTV}, 8'h01);
    rd("b_stat_assert", 8'h42, 8'h42);
    ack();
    check_eq("b_intv_ack", {7'b0, INTV}, 8'h00);
    rd("b_pend_ack", 8'h41, 8'h00);
    rd("b_stat_svc", 8'h42, 8'h82);
    wr(8'h43, 8'h00);
    rd("b_stat_eoi", 8'h42, 8'h00);

    // 3. priority: sources 5 and 1 together
    wr(8'h40, 8'hFF);
    IRQ = 8'h22; tick(); IRQ = 8'h00;
    rd("p_pend", 8'h41, 8'h22);
    tick();
    check_eq("p_intv", {7'b0, INTV}, 8'h01);
    rd("p_stat1", 8'h42, 8'h41);
    tick();
    rd("p_stat_frozen", 8'h42, 8'h41);
    ack();
    rd("p_stat_svc", 8'h42, 8'h81);
    rd("p_pend_svc", 8'h41, 8'h20);
    wr(8'h43, 8'h00);
    check_eq("p_intv_eoi0", {7'b0, INTV}, 8'h00);
    tick();
    check_eq("p_intv_eoi2", {7'b0, INTV}, 8'h01);
    rd("p_stat5", 8'h42, 8'h45);
    ack();
    rd("p_stat5_svc", 8'h42, 8'h85);
    wr(8'h43, 8'h00);
    rd("p_stat_clean", 8'h42, 8'h00);

    // 4. masked pending source
    wr(8'h40, 8'h00);
    IRQ = 8'h08; tick(); IRQ = 8'h00;
    tick(); tick();
    rd("m_pend", 8'h41, 8'h08);
    check_eq("m_intv_masked", {7'b0, INTV}, 8'h00);
    wr(8'h40, 8'h08);
    check_eq("m_intv_wr", {7'b0, INTV}, 8'h00);
    tick();
    check_eq("m_intv_on", {7'b0, INTV}, 8'h01);
    rd("m_stat", 8'h42, 8'h43);
    wr(8'h40, 8'h00);
    tick();
    check_eq("m_intv_off", {7'b0, INTV}, 8'h00);
    rd("m_stat_idle", 8'h42, 8'h00);
    check_eq("m_state_idle", {6'b0, dut.state_q}, {6'b0, IDLE});
    rd("m_pend_kept", 8'h41, 8'h08);
    wr(8'h41, 8'h08);
    rd("m_pend_w1c", 8'h41, 8'h00);

    // 5. W1C collides with a new edge; stray ack and EOI
    IRQ = 8'h01; PORT_ID = 8'h41; OUT_PORT = 8'h01; IO_STRB = 1'b1;
    tick();
    IRQ = 8'h00; IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
    rd("c_set_wins", 8'h41, 8'h01);
    ack();
    rd("c_stray_ack_stat", 8'h42, 8'h00);
    rd("c_stray_ack_pend", 8'h41, 8'h01);
    wr(8'h40, 8'h01);
    tick();
    rd("c_assert", 8'h42, 8'h40);
    wr(8'h43, 8'h00);
    rd("c_stray_eoi", 8'h42, 8'h40);
    check_eq("c_intv_after_eoi", {7'b0, INTV}, 8'h01);
    ack();
    rd("c_svc", 8'h42, 8'h80);
    wr(8'h43, 8'h00);
    rd("c_idle", 8'h42, 8'h00);

    // 6. reset in SERVICE with new pending edges
    wr(8'h40, 8'hFF);
    IRQ = 8'h10; tick(); IRQ = 8'h00;
    tick();
    ack();
    rd("r_svc", 8'h42, 8'h84);
    IRQ = 8'h30; tick(); IRQ = 8'h00;
    rd("r_pend", 8'h41, 8'h30);
    check_eq("r_intv_svc", {7'b0, INTV}, 8'h00);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check_eq("r_intv", {7'b0, INTV}, 8'h00);
    rd("r_mask", 8'h40, 8'h00);
    rd("r_pend0", 8'h41, 8'h00);
    rd("r_stat", 8'h42, 8'h00);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
